// File: rtl/ex_muldiv_iter.sv
// ex_muldiv_iter: iterative shift-add multiply / restoring divide for the EX stage, start/busy/done handshake
//   clk      rising-edge clock
//   reset    asynchronous active-low reset
//   start    request, sampled only in IDLE
//   op       00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   flush    abort the operation in flight, no done pulse
//   a, b     multiplicand/dividend, multiplier/divisor
//   busy     state != IDLE
//   done     one-cycle pulse, hi/lo/div_err valid
//   hi, lo   product[2W-1:W]/remainder, product[W-1:0]/quotient
//   div_err  divide fault flag, qualified by done
//   MULDIV_DIV_EN  defined: divider built; undefined: DIV/DIVU finish at once with div_err=1
module ex_muldiv_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             flush,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_err
);
`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, CALC, ADJ, DONE} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic sa_q, sb_q, sa, sb, accept, neg, err_n;
  logic [WIDTH-1:0] opnd_q, ma, mb, ld_acc, ld_opnd, hi_n, lo_n;
  logic [2*WIDTH-1:0] acc_q, acc_mul, acc_step, prod;
  logic [WIDTH:0] msum;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign accept = state_q == IDLE && start && !flush;
  assign sa = !op[0] && a[WIDTH-1];
  assign sb = !op[0] && b[WIDTH-1];
  assign ma = sa ? -a : a;
  assign mb = sb ? -b : b;
  // multiply: acc = {partial sum, multiplier}; add the multiplicand when the low bit is set, then shift right
  assign msum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign acc_mul = {msum, acc_q[WIDTH-1:1]};
  assign neg = sa_q ^ sb_q;
  assign prod = neg ? -acc_q : acc_q;
`ifdef MULDIV_DIV_EN
  logic is_div_q, ge, div0;
  logic [WIDTH-1:0] rem_q, rem_nx;
  logic [WIDTH:0] shl;
  // divide: acc low half holds the dividend shifting out and the quotient shifting in
  assign shl = {rem_q, acc_q[WIDTH-1]};
  assign ge = shl >= {1'b0, opnd_q};
  assign rem_nx = ge ? WIDTH'(shl - {1'b0, opnd_q}) : shl[WIDTH-1:0];
  assign div0 = opnd_q == '0;
  assign ld_acc = op[1] ? ma : mb;
  assign ld_opnd = op[1] ? mb : ma;
  assign acc_step = is_div_q ? {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], ge} : acc_mul;
  // remainder follows the dividend sign, so a zero divisor returns the raw dividend in hi
  assign hi_n = is_div_q ? (sa_q ? -rem_q : rem_q) : prod[2*WIDTH-1:WIDTH];
  assign lo_n = is_div_q ? (div0 ? '1 : neg ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]) : prod[WIDTH-1:0];
  assign err_n = is_div_q && div0;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      is_div_q <= 1'b0;
      rem_q <= '0;
    end else if (accept) begin
      is_div_q <= op[1];
      rem_q <= '0;
    end else if (state_q == CALC) begin
      rem_q <= rem_nx;
    end
`else
  assign ld_acc = mb;
  assign ld_opnd = ma;
  assign acc_step = acc_mul;
  assign hi_n = prod[2*WIDTH-1:WIDTH];
  assign lo_n = prod[WIDTH-1:0];
  assign err_n = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = (op[1] && !DIV_EN) ? DONE : CALC;
      CALC: if (cnt_q == CNT_W'(WIDTH-1)) state_d = ADJ;
      ADJ:  state_d = DONE;
      DONE: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      sa_q <= 1'b0;
      sb_q <= 1'b0;
      opnd_q <= '0;
      acc_q <= '0;
      hi <= '0;
      lo <= '0;
      div_err <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q <= '0;
        sa_q <= sa;
        sb_q <= sb;
        opnd_q <= ld_opnd;
        acc_q <= {{WIDTH{1'b0}}, ld_acc};
        div_err <= !DIV_EN && op[1];
        if (!DIV_EN && op[1]) begin
          hi <= '0;
          lo <= '0;
        end
      end else if (state_q == CALC) begin
        cnt_q <= cnt_q + 1'b1;
        acc_q <= acc_step;
      end else if (state_q == ADJ && !flush) begin
        hi <= hi_n;
        lo <= lo_n;
        div_err <= err_n;
      end
    end
endmodule

// File: tb/tb_ex_muldiv_iter.sv
// tb_ex_muldiv_iter: directed self-checking bench for ex_muldiv_iter
module tb_ex_muldiv_iter;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0, flush = 1'b0;
  logic [1:0] op = 2'b00;
  logic [31:0] a = '0, b = '0;
  logic busy, done, div_err;
  logic [31:0] hi, lo;
  int total = 0, passed = 0, fails = 0;
  int lat;
  bit bsy, seen;
  ex_muldiv_iter #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .flush(flush),
    .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo), .div_err(div_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input bit poke,
                        output int l, output bit bs);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1 start = 1'b0;
    l = 0;
    bs = 1'b1;
    while (l < 100) begin
      @(negedge clk);
      if (!busy) bs = 1'b0;
      if (done) break;
      if (poke && l == 5) begin start = 1'b1; op = 2'b00; a = 32'd5; b = 32'd5; end
      if (poke && l == 6) start = 1'b0;
      @(posedge clk);
      l++;
    end
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_err", div_err, 0);
    reset = 1'b1;
    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, lat, bsy);
    chk("multu_lat", lat, 33);
    chk("multu_busy", bsy, 1);
    chk("multu_hi", hi, 32'hFFFFFFFE);
    chk("multu_lo", lo, 32'h00000001);
    chk("multu_err", div_err, 0);
    @(negedge clk);
    chk("after_done", done, 0);
    chk("after_busy", busy, 0);
    run_op(2'b00, -32'sd7, 32'd3, 1'b0, lat, bsy);
    chk("mult_neg_hi", hi, 32'hFFFFFFFF);
    chk("mult_neg_lo", lo, 32'hFFFFFFEB);
    run_op(2'b00, 32'h80000000, 32'h80000000, 1'b0, lat, bsy);
    chk("mult_min_hi", hi, 32'h40000000);
    chk("mult_min_lo", lo, 32'h0);
    chk("mult_min_lat", lat, 33);
`ifdef MULDIV_DIV_EN
    run_op(2'b10, -32'sd7, 32'd2, 1'b0, lat, bsy);
    chk("div_lat", lat, 33);
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);
    chk("div_err", div_err, 0);
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, lat, bsy);
    chk("div_ovf_lo", lo, 32'h80000000);
    chk("div_ovf_hi", hi, 32'h0);
    chk("div_ovf_err", div_err, 0);
    run_op(2'b11, 32'd7, 32'd0, 1'b0, lat, bsy);
    chk("divu0_lo", lo, 32'hFFFFFFFF);
    chk("divu0_hi", hi, 32'd7);
    chk("divu0_err", div_err, 1);
    chk("divu0_lat", lat, 33);
    run_op(2'b10, -32'sd7, 32'd0, 1'b0, lat, bsy);
    chk("div0_neg_lo", lo, 32'hFFFFFFFF);
    chk("div0_neg_hi", hi, 32'hFFFFFFF9);
    chk("div0_neg_err", div_err, 1);
    run_op(2'b11, 32'd100, 32'd7, 1'b0, lat, bsy);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);
`else
    run_op(2'b11, 32'd10, 32'd3, 1'b0, lat, bsy);
    chk("nodiv_lat", lat, 0);
    chk("nodiv_hi", hi, 32'h0);
    chk("nodiv_lo", lo, 32'h0);
    chk("nodiv_err", div_err, 1);
    @(negedge clk);
    chk("nodiv_idle", busy, 0);
`endif
    run_op(2'b01, 32'd2, 32'd3, 1'b0, lat, bsy);
    chk("err_clear", div_err, 0);
    chk("small_lo", lo, 32'd6);
    run_op(2'b01, 32'd100, 32'd200, 1'b1, lat, bsy);
    chk("poke_lat", lat, 33);
    chk("poke_hi", hi, 32'h0);
    chk("poke_lo", lo, 32'h4E20);
    @(negedge clk);
    chk("poke_no_queue", busy, 0);
    @(negedge clk);
    start = 1'b1; op = 2'b01; a = 32'd7; b = 32'd9;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_busy", busy, 0);
    flush = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    chk("flush_no_done", seen, 0);
    chk("flush_hi", hi, 32'h0);
    chk("flush_lo", lo, 32'h4E20);
    start = 1'b1; flush = 1'b1;
    @(negedge clk);
    chk("flush_start", busy, 0);
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    start = 1'b1; op = 2'b01; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    #1 reset = 1'b0;
    #1;
    chk("async_busy", busy, 0);
    chk("async_done", done, 0);
    chk("async_hi", hi, 0);
    chk("async_lo", lo, 0);
    @(negedge clk);
    reset = 1'b1;
    run_op(2'b01, 32'd3, 32'd5, 1'b0, lat, bsy);
    chk("post_rst_lat", lat, 33);
    chk("post_rst_lo", lo, 32'd15);
    chk("post_rst_hi", hi, 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
